// File: rtl/clock24_pkg.sv
// Shared types and digit limits for the 24-hour clock core.
package clock24_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [2:0] LIM_TENS      = 3'd5;
    localparam logic [3:0] LIM_UNITS     = 4'd9;
    localparam logic [1:0] LIM_HOUR10    = 2'd2;
    localparam logic [3:0] LIM_HOUR1_TOP = 4'd3;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit register: synchronous clear, increment with wrap at a
// run-time limit, and a carry-out asserted on the wrapping increment.
module bcd_digit_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] q_o,
    output logic         carry_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // next-state: clear beats increment
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = {W{1'b0}};
        end else if (inc_i) begin
            q_d = (q_q == limit_i) ? {W{1'b0}} : q_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q_d = q_q;
        end
    end

    // digit register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o     = q_q;
    assign carry_o = inc_i && !clr_i && (q_q == limit_i);

endmodule

// File: rtl/clock24_core.sv
// 24-hour HH:MM:SS clock with run/set-hour/set-minute modes and a
// four-digit multiplexed HH:MM display scan with blinking of the field being set.
module clock24_core
    import clock24_pkg::*;
#(
    parameter int BLINK_EN = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       ENABLE_kHz,
    input  logic       EN05,
    input  logic       BTN_MODE,
    input  logic       BTN_UP,
    output logic [1:0] HOUR10,
    output logic [3:0] HOUR1,
    output logic [2:0] MIN10,
    output logic [3:0] MIN1,
    output logic [2:0] SEC10,
    output logic [3:0] SEC1,
    output logic [3:0] DIGIT_SEL,
    output logic [3:0] DIGIT_BCD,
    output logic       BLANK,
    output logic       CARRY_DAY
);

    mode_e      state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       en05_q;
    logic       carry_day_q, carry_day_d;

    logic       tick_s, up_s, sec_clr_s;
    logic       s1_c_s, s10_c_s, m1_c_s, m10_c_s, h1_c_s, h10_c_s;
    logic [3:0] h1_lim_s;
    logic [3:0] sel_s, bcd_s;
    logic       blank_s;

    assign tick_s    = (state_q == MODE_RUN) && ENABLE;
    assign up_s      = BTN_UP && !BTN_MODE;
    assign sec_clr_s = (state_q == MODE_SET_MIN) && BTN_MODE;
    // hours units wrap at 3 only while the tens digit is 2 (23 -> 00)
    assign h1_lim_s  = (HOUR10 == LIM_HOUR10) ? LIM_HOUR1_TOP : LIM_UNITS;

    bcd_digit_cnt #(.W(4)) u_sec1 (
        .clk_i(CLK), .rst_i(RESET), .clr_i(sec_clr_s), .inc_i(tick_s),
        .limit_i(LIM_UNITS), .q_o(SEC1), .carry_o(s1_c_s));

    bcd_digit_cnt #(.W(3)) u_sec10 (
        .clk_i(CLK), .rst_i(RESET), .clr_i(sec_clr_s), .inc_i(s1_c_s),
        .limit_i(LIM_TENS), .q_o(SEC10), .carry_o(s10_c_s));

    bcd_digit_cnt #(.W(4)) u_min1 (
        .clk_i(CLK), .rst_i(RESET), .clr_i(1'b0),
        .inc_i(s10_c_s || ((state_q == MODE_SET_MIN) && up_s)),
        .limit_i(LIM_UNITS), .q_o(MIN1), .carry_o(m1_c_s));

    bcd_digit_cnt #(.W(3)) u_min10 (
        .clk_i(CLK), .rst_i(RESET), .clr_i(1'b0), .inc_i(m1_c_s),
        .limit_i(LIM_TENS), .q_o(MIN10), .carry_o(m10_c_s));

    // minute wrap reaches the hours only while running
    bcd_digit_cnt #(.W(4)) u_hour1 (
        .clk_i(CLK), .rst_i(RESET), .clr_i(1'b0),
        .inc_i((m10_c_s && (state_q == MODE_RUN)) || ((state_q == MODE_SET_HOUR) && up_s)),
        .limit_i(h1_lim_s), .q_o(HOUR1), .carry_o(h1_c_s));

    bcd_digit_cnt #(.W(2)) u_hour10 (
        .clk_i(CLK), .rst_i(RESET), .clr_i(1'b0), .inc_i(h1_c_s),
        .limit_i(LIM_HOUR10), .q_o(HOUR10), .carry_o(h10_c_s));

    // mode FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            MODE_RUN:      state_d = BTN_MODE ? MODE_SET_HOUR : MODE_RUN;
            MODE_SET_HOUR: state_d = BTN_MODE ? MODE_SET_MIN  : MODE_SET_HOUR;
            MODE_SET_MIN:  state_d = BTN_MODE ? MODE_RUN      : MODE_SET_MIN;
            default:       state_d = MODE_RUN;
        endcase
    end

    // scan index and day-carry next values
    always_comb begin
        idx_d       = ENABLE_kHz ? idx_q + 2'd1 : idx_q;
        carry_day_d = h10_c_s && (state_q == MODE_RUN);
    end

    // control registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= MODE_RUN;
            idx_q       <= 2'd0;
            en05_q      <= 1'b0;
            carry_day_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            en05_q      <= EN05;
            carry_day_q <= carry_day_d;
        end
    end

    // display digit select and value, decoded from registered state
    always_comb begin
        sel_s = 4'b0001;
        bcd_s = MIN1;
        case (idx_q)
            2'd0: begin sel_s = 4'b0001; bcd_s = MIN1;            end
            2'd1: begin sel_s = 4'b0010; bcd_s = {1'b0, MIN10};   end
            2'd2: begin sel_s = 4'b0100; bcd_s = HOUR1;           end
            2'd3: begin sel_s = 4'b1000; bcd_s = {2'b00, HOUR10}; end
            default: begin sel_s = 4'b0001; bcd_s = MIN1;         end
        endcase
    end

    // blank the field being edited during the high half of the blink period
    always_comb begin
        blank_s = 1'b0;
        if ((BLINK_EN != 0) && en05_q) begin
            case (state_q)
                MODE_SET_HOUR: blank_s = idx_q[1];
                MODE_SET_MIN:  blank_s = !idx_q[1];
                default:       blank_s = 1'b0;
            endcase
        end else begin
            blank_s = 1'b0;
        end
    end

    assign DIGIT_SEL = sel_s;
    assign DIGIT_BCD = bcd_s;
    assign BLANK     = blank_s;
    assign CARRY_DAY = carry_day_q;

endmodule

// File: tb/tb_clock24_core.sv
// Directed bench for clock24_core: a vector table plus hand-written
// sequences for day wrap, setting, blinking and reset.
module tb_clock24_core;

    logic       CLK = 1'b0;
    logic       RESET, ENABLE, ENABLE_kHz, EN05, BTN_MODE, BTN_UP;
    logic [1:0] HOUR10;
    logic [3:0] HOUR1, MIN1, SEC1, DIGIT_SEL, DIGIT_BCD;
    logic [2:0] MIN10, SEC10;
    logic       BLANK, CARRY_DAY;
    logic [23:0] time_w;

    int total = 0;
    int bad   = 0;

    clock24_core #(.BLINK_EN(1)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .ENABLE_kHz(ENABLE_kHz),
        .EN05(EN05), .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP),
        .HOUR10(HOUR10), .HOUR1(HOUR1), .MIN10(MIN10), .MIN1(MIN1),
        .SEC10(SEC10), .SEC1(SEC1), .DIGIT_SEL(DIGIT_SEL), .DIGIT_BCD(DIGIT_BCD),
        .BLANK(BLANK), .CARRY_DAY(CARRY_DAY));

    always #4 CLK = ~CLK;

    assign time_w = {2'b00, HOUR10, HOUR1, 1'b0, MIN10, MIN1, 1'b0, SEC10, SEC1};

    typedef struct packed {
        logic        mode;
        logic        up;
        logic        en;
        logic        khz;
        logic        en05;
        logic [23:0] t;
        logic        cd;
        logic [3:0]  sel;
        logic [3:0]  bcd;
        logic        blk;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic m, input logic u, input logic e, input logic k);
        BTN_MODE   = m;
        BTN_UP     = u;
        ENABLE     = e;
        ENABLE_kHz = k;
        @(posedge CLK);
        #1;
        BTN_MODE   = 1'b0;
        BTN_UP     = 1'b0;
        ENABLE     = 1'b0;
        ENABLE_kHz = 1'b0;
    endtask

    task automatic rep(input int n, input logic m, input logic u, input logic e);
        for (int i = 0; i < n; i++) cyc(m, u, e, 1'b0);
    endtask

    task automatic do_reset();
        EN05  = 1'b0;
        RESET = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
    endtask

    int saw_cd;

    initial begin
        RESET = 1'b1; ENABLE = 1'b0; ENABLE_kHz = 1'b0; EN05 = 1'b0;
        BTN_MODE = 1'b0; BTN_UP = 1'b0;
        //                 mode  up    en    khz   en05  time        cd    sel      bcd   blk
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000001, 1'b0, 4'b0001, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 4'b0001, 4'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000002, 1'b0, 4'b0010, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000003, 1'b0, 4'b0010, 4'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000003, 1'b0, 4'b0010, 4'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h010003, 1'b0, 4'b0010, 4'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h020003, 1'b0, 4'b0100, 4'd2, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h020003, 1'b0, 4'b1000, 4'd0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h020003, 1'b0, 4'b0001, 4'd0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h020003, 1'b0, 4'b0001, 4'd0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h020103, 1'b0, 4'b0001, 4'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h020103, 1'b0, 4'b0001, 4'd1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h020100, 1'b0, 4'b0001, 4'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h020101, 1'b0, 4'b0001, 4'd1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h020101, 1'b0, 4'b0001, 4'd1, 1'b0};

        rep(2, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_time", {8'h0, time_w}, 32'h0);
        chk("reset_sel",  {28'h0, DIGIT_SEL}, 32'h1);
        chk("reset_bcd",  {28'h0, DIGIT_BCD}, 32'h0);
        chk("reset_blank", {31'h0, BLANK}, 32'h0);
        chk("reset_carry", {31'h0, CARRY_DAY}, 32'h0);

        for (int i = 0; i < 15; i++) begin
            EN05 = vecs[i].en05;
            cyc(vecs[i].mode, vecs[i].up, vecs[i].en, vecs[i].khz);
            chk($sformatf("vec%0d_time", i),  {8'h0, time_w}, {8'h0, vecs[i].t});
            chk($sformatf("vec%0d_carry", i), {31'h0, CARRY_DAY}, {31'h0, vecs[i].cd});
            chk($sformatf("vec%0d_sel", i),   {28'h0, DIGIT_SEL}, {28'h0, vecs[i].sel});
            chk($sformatf("vec%0d_bcd", i),   {28'h0, DIGIT_BCD}, {28'h0, vecs[i].bcd});
            chk($sformatf("vec%0d_blank", i), {31'h0, BLANK}, {31'h0, vecs[i].blk});
        end

        // day wrap from 23:59:58
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(23, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(59, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_set", {8'h0, time_w}, 32'h235900);
        rep(58, 1'b0, 1'b0, 1'b1);
        chk("wrap_58", {8'h0, time_w}, 32'h235958);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_59", {8'h0, time_w}, 32'h235959);
        chk("wrap_59_cd", {31'h0, CARRY_DAY}, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_00", {8'h0, time_w}, 32'h000000);
        chk("wrap_00_cd", {31'h0, CARRY_DAY}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_cd_drop", {31'h0, CARRY_DAY}, 32'h0);
        chk("wrap_hold", {8'h0, time_w}, 32'h000000);

        // hour setting wraps through 23 with time frozen
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(12, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(34, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(56, 1'b0, 1'b0, 1'b1);
        chk("set_123456", {8'h0, time_w}, 32'h123456);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        saw_cd = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (CARRY_DAY) saw_cd++;
        end
        chk("sethour_03", {8'h0, time_w}, 32'h033456);
        chk("sethour_no_cd", saw_cd, 32'd0);
        rep(3, 1'b0, 1'b0, 1'b1);
        chk("sethour_frozen", {8'h0, time_w}, 32'h033456);

        // minute setting wraps 59 -> 00, exit to RUN clears seconds
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(7, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(58, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(5, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("setmin_start", {8'h0, time_w}, 32'h075805);
        rep(3, 1'b0, 1'b1, 1'b0);
        chk("setmin_wrap", {8'h0, time_w}, 32'h070105);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("setmin_exit", {8'h0, time_w}, 32'h070100);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("setmin_run", {8'h0, time_w}, 32'h070101);

        // blink pattern in SET_HOUR
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        EN05 = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("blink_idx0", {31'h0, BLANK}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("blink_idx1", {31'h0, BLANK}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("blink_idx2", {31'h0, BLANK}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("blink_idx3", {31'h0, BLANK}, 32'h1);
        chk("blink_sel3", {28'h0, DIGIT_SEL}, 32'h8);
        EN05 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("noblink_%0d", i), {31'h0, BLANK}, 32'h0);
        end

        // reset in the middle of minute setting
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(19, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rep(45, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_pre", {8'h0, time_w}, 32'h194500);
        EN05  = 1'b1;
        RESET = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        RESET = 1'b0;
        chk("rst_mid_time", {8'h0, time_w}, 32'h0);
        chk("rst_mid_sel", {28'h0, DIGIT_SEL}, 32'h1);
        chk("rst_mid_blank", {31'h0, BLANK}, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_mid_run", {8'h0, time_w}, 32'h000001);
        chk("rst_mid_noblank", {31'h0, BLANK}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock24_core.md
CLOCK24_CORE -- requirements
Module: clock24_core

Interface
REQ-001 Parameter BLINK_EN, default 1, 1 = blank the digits being set while EN05 is high; 0 = never blank.
REQ-002 CLK  input  1  system clock (125 MHz); all logic on rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 ENABLE  input  1  1 Hz tick, one-cycle pulse.
REQ-005 ENABLE_kHz  input  1  display scan tick, one-cycle pulse.
REQ-006 EN05  input  1  blink level, 0.5 s high / 0.5 s low.
REQ-007 BTN_MODE  input  1  debounced one-cycle press pulse, cycles the mode.
REQ-008 BTN_UP  input  1  debounced one-cycle press pulse, increments the field being set.
REQ-009 HOUR10  output  2  hours tens digit, BCD 0..2.
REQ-010 HOUR1  output  4  hours units digit, BCD 0..9.
REQ-011 MIN10  output  3  minutes tens digit, BCD 0..5.
REQ-012 MIN1  output  4  minutes units digit, BCD 0..9.
REQ-013 SEC10  output  3  seconds tens digit, BCD 0..5.
REQ-014 SEC1  output  4  seconds units digit, BCD 0..9.
REQ-015 DIGIT_SEL  output  4  one-hot active-high digit enable.
REQ-016 DIGIT_BCD  output  4  BCD value for the selected digit.
REQ-017 BLANK  output  1  1 = the display blanks the selected digit.
REQ-018 CARRY_DAY  output  1  one-cycle pulse on wrap from 23:59:59 to 00:00:00.

Function
REQ-019 Mode FSM states and transitions: RUN -> SET_HOUR -> SET_MIN -> RUN; each BTN_MODE pulse advances exactly one state.
REQ-020 RUN: each ENABLE pulse increments the time by one second through the BCD cascade SEC1 -> SEC10 -> MIN1 -> MIN10 -> hours; every digit field wraps at its decimal limit.
REQ-021 Hours wrap: 23 -> 00; 09 -> 10 and 19 -> 20 propagate into HOUR10; the hour value never exceeds 23.
REQ-022 At 23:59:59 with ENABLE in RUN, the next state is 00:00:00 and CARRY_DAY = 1 for that single cycle only.
REQ-023 SET_HOUR / SET_MIN: ENABLE is ignored; the time does not advance.
REQ-024 SET_HOUR: BTN_UP increments hours 23 -> 00; minutes are unaffected and CARRY_DAY stays 0.
REQ-025 SET_MIN: BTN_UP increments minutes 59 -> 00; hours are unaffected.
REQ-026 Transition SET_MIN -> RUN clears SEC10/SEC1 to 0 on the same edge.
REQ-027 BTN_MODE and BTN_UP in the same cycle: the mode change wins; BTN_UP is ignored.
REQ-028 BTN_MODE and ENABLE in the same cycle while in RUN: the increment is applied and the state becomes SET_HOUR on that same edge.
REQ-029 The BTN_UP pulse is ignored in RUN.
REQ-030 A 2-bit scan index advances 0 -> 1 -> 2 -> 3 -> 0 on each ENABLE_kHz pulse and holds otherwise.
REQ-031 Scan index mapping:
- 0: DIGIT_SEL = 0001, DIGIT_BCD = MIN1
- 1: DIGIT_SEL = 0010, DIGIT_BCD = MIN10
- 2: DIGIT_SEL = 0100, DIGIT_BCD = HOUR1
- 3: DIGIT_SEL = 1000, DIGIT_BCD = HOUR10
- Narrower fields are zero-extended to 4 bits.
REQ-032 BLANK = 1 only when all of these hold:
- BLINK_EN = 1
- EN05 = 1
- state SET_HOUR with index 2 or 3, or state SET_MIN with index 0 or 1
REQ-033 All outputs are registered, or decoded combinationally only from registered state; there is no combinational path from any input to any output.

Reset
REQ-034 With RESET high at a CLK edge, the following values SHALL hold:
- state = RUN
- time = 00:00:00
- scan index = 0
- DIGIT_SEL = 0001
- DIGIT_BCD = 0
- BLANK = 0
- CARRY_DAY = 0
REQ-035 RESET overrides every other input in the same cycle, including mid-set and on the wrap cycle.

Structure
REQ-036 A shared package holds the mode-state enumeration (RUN, SET_HOUR, SET_MIN) and the digit-limit constants (5, 9, 2, 3).
REQ-037 One sub-module, bcd_digit_cnt, holds one BCD digit register with increment, wrap-at-limit and carry-out, instantiated once per digit.

Verification
REQ-038 Preload 23:59:58, RUN, two ENABLE pulses -> 23:59:59, then 00:00:00 with CARRY_DAY high for exactly 1 cycle.
REQ-039 Time 12:34:56, BTN_MODE, then 15 BTN_UP -> hours read 03, minutes 34, and time is frozen through ENABLE pulses.
REQ-040 In SET_MIN at 07:58, 3 BTN_UP then BTN_MODE -> 07:01:00, state RUN, hour unchanged.
REQ-041 SET_HOUR, EN05 = 1, 4 ENABLE_kHz pulses -> BLANK pattern over index 0..3 is 0,0,1,1; with EN05 = 0 it is all 0.
REQ-042 BTN_MODE and BTN_UP in the same cycle in SET_HOUR -> state becomes SET_MIN and hours are unchanged.
REQ-043 RESET asserted for 1 cycle mid-SET_MIN at 19:45 -> next cycle state RUN, 00:00:00, DIGIT_SEL = 0001.
